// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the 4x4 keypad scanner.
// Scanner states, {row,col} key-code map, lowest-low-row priority.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } kp_state_t;

  // Indexed {row,col}; row 0 is the top row, col 0 the leftmost.
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  // Lowest-index low row; 0 when all rows are idle.
  function automatic logic [1:0] first_low(input logic [3:0] r);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!r[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scan 4x4 keypad with press/release debounce.
// In: clk, rst, row[3:0]. Out: col[3:0], keypad_value, keypress, key_held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int clk_freq    = 50_000_000,
  parameter int stable_time = 10,
  parameter int col_dwell   = 50_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] keypad_value,
  output logic       keypress,
  output logic       key_held
);

  localparam int DB_RAW = clk_freq / 1000 * stable_time;
  localparam int DB     = (DB_RAW < 1) ? 1 : DB_RAW;
  localparam int DWELL  = (col_dwell < 2) ? 2 : col_dwell;
  localparam int DW     = $clog2(DWELL);
  localparam int CW     = (DB < 2) ? 1 : $clog2(DB + 1);

  localparam logic [DW-1:0] DW_LAST = DW'(DWELL - 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DB - 1);

  kp_state_t     state, state_n;
  logic [3:0]    row_m, row_s;
  logic [DW-1:0] dwell, dwell_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    col_idx, col_n;
  logic [1:0]    cand, cand_n;
  logic [3:0]    value_n;
  logic          press_n, held_n;
  logic          row_idle;
  logic [1:0]    low_idx;

  assign row_idle = &row_s;
  assign low_idx  = first_low(row_s);
  assign col      = ~(4'b0001 << col_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_m        <= 4'hF;
      row_s        <= 4'hF;
      state        <= SCAN;
      dwell        <= '0;
      cnt          <= '0;
      col_idx      <= 2'd0;
      cand         <= 2'd0;
      keypad_value <= 4'h0;
      keypress     <= 1'b0;
      key_held     <= 1'b0;
    end else begin
      row_m        <= row;
      row_s        <= row_m;
      state        <= state_n;
      dwell        <= dwell_n;
      cnt          <= cnt_n;
      col_idx      <= col_n;
      cand         <= cand_n;
      keypad_value <= value_n;
      keypress     <= press_n;
      key_held     <= held_n;
    end
  end

  always_comb begin
    state_n = state;
    dwell_n = dwell;
    cnt_n   = cnt;
    col_n   = col_idx;
    cand_n  = cand;
    value_n = keypad_value;
    press_n = 1'b0;
    held_n  = key_held;
    unique case (state)
      SCAN: begin
        if (dwell == DW_LAST) begin
          dwell_n = '0;
          if (row_idle) begin
            col_n = col_idx + 2'd1;
          end else begin
            cand_n  = low_idx;
            cnt_n   = '0;
            state_n = DEBOUNCE;
          end
        end else begin
          dwell_n = dwell + DW'(1);
        end
      end
      DEBOUNCE: begin
        if (!row_idle && low_idx == cand) begin
          if (cnt == DB_LAST) begin
            state_n = HELD;
            cnt_n   = '0;
            value_n = KEY_MAP[{cand, col_idx}];
            press_n = 1'b1;
            held_n  = 1'b1;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end else begin
          // Bounce: rescan the same column from the start.
          state_n = SCAN;
          dwell_n = '0;
        end
      end
      HELD: begin
        if (row_idle) begin
          if (cnt == DB_LAST) begin
            state_n = SCAN;
            cnt_n   = '0;
            dwell_n = '0;
            held_n  = 1'b0;
            col_n   = col_idx + 2'd1;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end else begin
          cnt_n = '0;
        end
      end
      default: state_n = SCAN;
    endcase
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed checks of scan, debounce and strobe.
// Keypad model pulls a row low when its pressed key's column is driven.
module tb_keypad_scanner;

  logic       clk;
  logic       rst;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] keypad_value;
  logic       keypress;
  logic       key_held;

  logic [15:0] keys;
  int checks;
  int failures;
  int n_press;
  int n_long;
  int last_val;
  int base;
  logic kp_prev;

  keypad_scanner #(
    .clk_freq   (1000),
    .stable_time(3),
    .col_dwell  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .row         (row),
    .col         (col),
    .keypad_value(keypad_value),
    .keypress    (keypress),
    .key_held    (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      row[r] = !(|(keys[r*4 +: 4] & ~col));
    end
  end

  initial begin
    n_press  = 0;
    n_long   = 0;
    last_val = 0;
    kp_prev  = 1'b0;
  end

  always @(negedge clk) begin
    if (keypress) begin
      n_press  = n_press + 1;
      last_val = int'(keypad_value);
      if (kp_prev) n_long = n_long + 1;
    end
    kp_prev = keypress;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_held(input logic lvl, input int maxc,
                           input string tag);
    for (int i = 0; i < maxc; i++) begin
      if (key_held === lvl) break;
      @(negedge clk);
    end
    check(tag, int'(key_held), int'(lvl));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] rot [4];
    rot[0] = 4'b1110;
    rot[1] = 4'b1101;
    rot[2] = 4'b1011;
    rot[3] = 4'b0111;
    checks   = 0;
    failures = 0;
    keys     = 16'h0;
    rst      = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_col", int'(col), 4'b1110);
    check("rst_val", int'(keypad_value), 0);
    check("rst_kp", int'(keypress), 0);
    check("rst_held", int'(key_held), 0);

    rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      check($sformatf("idle_col%0d", i), int'(col), int'(rot[(i/4)%4]));
      @(negedge clk);
    end

    // '6' = row1/col2
    base = n_press;
    keys = 16'h0040;
    wait_held(1'b1, 100, "k6_held");
    repeat (18) @(negedge clk);
    check("k6_cnt", n_press - base, 1);
    check("k6_val", last_val, 6);
    check("k6_held20", int'(key_held), 1);
    check("k6_col", int'(col), 4'b1011);
    keys = 16'h0;
    repeat (4) @(negedge clk);
    check("k6_rel_early", int'(key_held), 1);
    @(negedge clk);
    check("k6_rel", int'(key_held), 0);
    check("k6_next_col", int'(col), 4'b0111);

    // 'D' = row3/col3 with a bounce inside debounce
    base = n_press;
    keys = 16'h8000;
    repeat (2) @(negedge clk);
    keys = 16'h0;
    repeat (2) @(negedge clk);
    keys = 16'h8000;
    repeat (4) @(negedge clk);
    check("kd_bounce", n_press - base, 0);
    wait_held(1'b1, 40, "kd_held");
    @(negedge clk);
    check("kd_cnt", n_press - base, 1);
    check("kd_val", last_val, 13);
    check("kd_out", int'(keypad_value), 13);
    keys = 16'h0;
    wait_held(1'b0, 40, "kd_rel");

    // '1' and '4' together, same column
    base = n_press;
    keys = 16'h0011;
    wait_held(1'b1, 100, "k14_held");
    @(negedge clk);
    check("k14_cnt", n_press - base, 1);
    check("k14_val", last_val, 1);
    keys = 16'h0;
    wait_held(1'b0, 40, "k14_rel");

    // Hold '0', add 'A', release '0' first
    base = n_press;
    keys = 16'h1000;
    wait_held(1'b1, 100, "k0_held");
    @(negedge clk);
    check("k0_val", last_val, 0);
    keys = 16'h1008;
    repeat (12) @(negedge clk);
    check("k0a_ignored", n_press - base, 1);
    check("k0a_out", int'(keypad_value), 0);
    keys = 16'h0008;
    wait_held(1'b0, 40, "k0_rel");
    check("k0_rel_cnt", n_press - base, 1);
    wait_held(1'b1, 100, "ka_held");
    @(negedge clk);
    check("ka_cnt", n_press - base, 2);
    check("ka_val", last_val, 10);
    keys = 16'h0;
    wait_held(1'b0, 40, "ka_rel");

    // Reset while a key is held
    base = n_press;
    keys = 16'h0040;
    wait_held(1'b1, 100, "r6_held");
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mrst_col", int'(col), 4'b1110);
    check("mrst_val", int'(keypad_value), 0);
    check("mrst_kp", int'(keypress), 0);
    check("mrst_held", int'(key_held), 0);
    keys = 16'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("mrst_col0", int'(col), 4'b1110);
    repeat (4) @(negedge clk);
    check("mrst_col1", int'(col), 4'b1101);
    check("mrst_cnt", n_press - base, 1);
    check("kp_width", n_long, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans the 4x4 matrix keypad by driving one column low at a time, sampling the row lines, debouncing the contact and emitting a hex key code with a one-cycle press strobe. It sits between the keypad pins (`col`/`row`) and the lock FSM/SSD logic, which consume `keypad_value` and `keypress`. Key release is also debounced, so exactly one `keypress` is issued per physical press.

## Interface
- `clk_freq`, 50_000_000: clock frequency in Hz.
- `stable_time`, 10: debounce time in ms. Debounce count DB = clk_freq/1000*stable_time cycles, minimum 1.
- `col_dwell`, 50_000: cycles each column is driven during scanning, minimum 2.

- `clk` in 1: system clock, single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `row` in 4: keypad rows, pulled up; low means a key in the driven column is closed. `row[0]` is the top row.
- `col` out 4: active-low column drive, exactly one bit low. `col[0]` is the leftmost column.
- `keypad_value` out 4: hex code of the last accepted key, held until the next accepted press.
- `keypress` out 1: one-cycle strobe on each accepted press.
- `key_held` out 1: high from acceptance until release is debounced.

## Operation
- Row input path: 2-FF synchronizer; all decisions use the synchronized `row_s`.
- Key map is `row[r]`/`col[c]` to code. Row 0: 1,2,3,A. Row 1: 4,5,6,B. Row 2: 7,8,9,C. Row 3: 0,F,E,D. Column index runs 0..3 left to right.
- States:
  - SCAN:
    - Dwell counter counts 0..col_dwell-1.
    - On the last dwell cycle, sample `row_s`.
    - If all rows are high: rotate `col` to the next column (3 wraps to 0) and clear the dwell counter.
    - If any row is low: latch (column, lowest-index low row) as the candidate, clear the stable counter, go to DEBOUNCE. The column is not rotated.
  - DEBOUNCE:
    - Hold the column.
    - Each cycle: if `row_s` still has the candidate row low and no lower-index row low, increment the stable counter. Otherwise go to SCAN with the dwell counter cleared on the same column.
    - When the stable counter reaches DB: load `keypad_value`, pulse `keypress`, set `key_held`, go to HELD.
  - HELD:
    - Hold the column.
    - If all rows are high, increment the release counter; any low row clears it.
    - When the release counter reaches DB: clear `key_held`, rotate to the next column, go to SCAN.
- Multiple keys:
  - In the same column, the lowest row index wins.
  - Keys in other columns are invisible while the column is held.
  - A second key pressed during HELD is ignored until the first key is fully released.
- Reset, at any time including mid-debounce or held:
  - `col`=4'b1110.
  - `keypad_value`=4'h0, `keypress`=0, `key_held`=0.
  - State SCAN, all counters 0, synchronizer flops 1 (rows idle).

## Timing
- `col` changes only on a dwell-counter wrap or on HELD exit; there is no overlap between columns.
- Press latency, from the first `row` low edge at the pins:
  - 2 cycles of synchronizer,
  - plus up to col_dwell wait for the sample point,
  - plus DB cycles of debounce,
  - plus 1 registered output cycle.
- `keypress` is high exactly one cycle. `keypad_value` changes in that same cycle and is stable before and after it.
- `key_held` rises with `keypress` and falls DB cycles after `row_s` returns to all-high.
- A bounce shorter than DB during DEBOUNCE produces no strobe. A bounce during HELD restarts the release count and produces no second strobe.
- Counters are sized $clog2 of their max+1. DB saturation is not needed because the counter is cleared on every exit.

## Structure
- Package `keypad_pkg`:
  - state enum `{SCAN, DEBOUNCE, HELD}`,
  - 16-entry key-map constant array indexed {row,col},
  - function `first_low(row)` returning the lowest low-row index.
- Single module; no sub-module needed. The synchronizer is inline.
- Drop-in replacement for the keypad portion of the SSD/keypad top: its ports map directly to `keypad_value`/`keypress`.

## Test plan
Bench parameters: clk_freq=1000, stable_time=3 (DB=3), col_dwell=4. The keypad model drives `row` low when the modeled key's column is driven low.

- Reset mid-HELD:
  - Assert `rst` → `col`=4'b1110, `keypad_value`=0, `keypress`=0, `key_held`=0 asynchronously.
  - After release, scanning restarts at col 0.
- Idle rotation, no key: `col` sequence 1110 →1101 →1011 →0111 →1110, each held 4 cycles.
- Press '6' (row1/col2), held 20 cycles:
  - Exactly one `keypress`, with `keypad_value`=4'h6.
  - `key_held` high until 3 cycles after `row_s` is idle.
  - Then `col` advances to 0111.
- Press 'D' (row3/col3) with a 2-cycle bounce in DEBOUNCE:
  - No strobe on the bounce.
  - After a clean hold, one strobe with `keypad_value`=4'hD.
- Simultaneous '1' and '4' (col0, rows 0 and 1) → one strobe, `keypad_value`=4'h1.
- Hold '0', press 'A' during HELD, release '0' while 'A' is still held:
  - No strobe for 'A' during HELD.
  - After '0' release completes, 'A' is detected on the next col-3 visit and strobes with 4'hA.
